neo_receiver: RTL and testbench

//  Receive end of the NeoPixel (WS2812-style) one-wire link driven by the controller's neo_data.

---
 rtl/neo_receiver.sv | 184 ++++++++++++++++++
 tb/tb_neo_receiver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/neo_receiver.sv
// WS2812-style one-wire receiver: decodes pulse-width bits into GRB pixels and detects the latch.
// Latency: line fall of bit 23 -> pixel_valid 4 cycles; no backpressure (strobes are unconditional).
module neo_receiver #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BIT_THRESH = 26,
  parameter int MIN_HIGH   = 8,
  parameter int MAX_HIGH   = 50,
  parameter int LATCH_LOW  = CLK_HZ / 20_000,
  parameter int NUM_PIXELS = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            neo_data,
  output logic                            pixel_valid,
  output logic [$clog2(NUM_PIXELS)-1:0]   pixel_index,
  output logic [7:0]                      green,
  output logic [7:0]                      red,
  output logic [7:0]                      blue,
  output logic                            frame_done,
  output logic [$clog2(NUM_PIXELS+1)-1:0] pixel_count,
  output logic                            error
);
  localparam int IW = $clog2(NUM_PIXELS);
  localparam int PW = $clog2(NUM_PIXELS + 1);
  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int LW = $clog2(LATCH_LOW + 1);
  localparam logic [HW-1:0] HIGH_SAT = HW'(MAX_HIGH + 1);
  localparam logic [HW-1:0] MIN_H    = HW'(MIN_HIGH);
  localparam logic [HW-1:0] MAX_H    = HW'(MAX_HIGH);
  localparam logic [HW-1:0] THR      = HW'(BIT_THRESH);
  localparam logic [LW-1:0] LOW_SAT  = LW'(LATCH_LOW);
  localparam logic [PW-1:0] PIX_MAX  = PW'(NUM_PIXELS);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync2_q, line_q;
  logic            rise, fall;
  logic [HW-1:0]   high_cnt_q, high_cnt_d;
  logic [LW-1:0]   low_cnt_q, low_cnt_d;
  logic [23:0]     sr_q, sr_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
  logic            word_done_q, word_done_d;
  logic            err_q, err_d;
  logic            pv_q, pv_d;
  logic            fd_q, fd_d;
  logic [PW-1:0]   pc_q, pc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      g_q, g_d, r_q, r_d, b_q, b_d;

  assign rise = sync2_q & ~line_q;
  assign fall = ~sync2_q & line_q;

  // A fall always arrives with low_cnt at 0, so a word and a latch can never complete together.
  always_comb begin
    high_cnt_d = high_cnt_q;
    low_cnt_d  = low_cnt_q;
    if (sync2_q) begin
      low_cnt_d = '0;
      if (rise)
        high_cnt_d = HW'(1);
      else if (high_cnt_q != HIGH_SAT)
        high_cnt_d = high_cnt_q + HW'(1);
    end else if (low_cnt_q != LOW_SAT) begin
      low_cnt_d = low_cnt_q + LW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    word_done_d = 1'b0;
    err_d       = err_q;
    pv_d        = 1'b0;
    fd_d        = 1'b0;
    pc_d        = pc_q;
    idx_d       = idx_q;
    g_d         = g_q;
    r_d         = r_q;
    b_d         = b_q;

    if (word_done_q) begin
      if (pix_cnt_q < PIX_MAX) begin
        pv_d      = 1'b1;
        idx_d     = pix_cnt_q[IW-1:0];
        g_d       = sr_q[23:16];
        r_d       = sr_q[15:8];
        b_d       = sr_q[7:0];
        pix_cnt_d = pix_cnt_q + PW'(1);
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      SYNC: if (low_cnt_q == LOW_SAT) state_d = IDLE;
      IDLE: if (rise) begin
        state_d   = HIGH;
        err_d     = 1'b0;
        bit_cnt_d = '0;
        pix_cnt_d = '0;
      end
      HIGH: if (fall) begin
        state_d = LOW;
        if (high_cnt_q < MIN_H || high_cnt_q > MAX_H) begin
          err_d = 1'b1;
        end else begin
          sr_d = {sr_q[22:0], (high_cnt_q >= THR)};
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d   = '0;
            word_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
        end else if (low_cnt_q == LOW_SAT) begin
          state_d = IDLE;
          fd_d    = 1'b1;
          pc_d    = pix_cnt_q;
          if (bit_cnt_q != 5'd0) err_d = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      line_q      <= 1'b0;
      state_q     <= SYNC;
      high_cnt_q  <= '0;
      low_cnt_q   <= '0;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      pix_cnt_q   <= '0;
      word_done_q <= 1'b0;
      err_q       <= 1'b0;
      pv_q        <= 1'b0;
      fd_q        <= 1'b0;
      pc_q        <= '0;
      idx_q       <= '0;
      g_q         <= '0;
      r_q         <= '0;
      b_q         <= '0;
    end else begin
      sync1_q     <= neo_data;
      sync2_q     <= sync1_q;
      line_q      <= sync2_q;
      state_q     <= state_d;
      high_cnt_q  <= high_cnt_d;
      low_cnt_q   <= low_cnt_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      word_done_q <= word_done_d;
      err_q       <= err_d;
      pv_q        <= pv_d;
      fd_q        <= fd_d;
      pc_q        <= pc_d;
      idx_q       <= idx_d;
      g_q         <= g_d;
      r_q         <= r_d;
      b_q         <= b_d;
    end
  end

  assign pixel_valid = pv_q;
  assign pixel_index = idx_q;
  assign green       = g_q;
  assign red         = r_q;
  assign blue        = b_q;
  assign frame_done  = fd_q;
  assign pixel_count = pc_q;
  assign error       = err_q;
endmodule

// File: tb/tb_neo_receiver.sv
// Drives randomized WS2812 pulse trains and compares against a pulse-list decoding model.
module tb_neo_receiver;
  localparam int BIT_THRESH = 26;
  localparam int MIN_HIGH   = 8;
  localparam int MAX_HIGH   = 50;
  localparam int LATCH_LOW  = 2500;
  localparam int NUM_PIXELS = 8;

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic       neo_data = 1'b0;
  logic       pixel_valid, frame_done, error;
  logic [2:0] pixel_index;
  logic [7:0] green, red, blue;
  logic [3:0] pixel_count;

  neo_receiver #(
    .CLK_HZ(50_000_000), .BIT_THRESH(BIT_THRESH), .MIN_HIGH(MIN_HIGH),
    .MAX_HIGH(MAX_HIGH), .LATCH_LOW(LATCH_LOW), .NUM_PIXELS(NUM_PIXELS)
  ) dut (
    .clock(clock), .reset(reset), .neo_data(neo_data),
    .pixel_valid(pixel_valid), .pixel_index(pixel_index),
    .green(green), .red(red), .blue(blue),
    .frame_done(frame_done), .pixel_count(pixel_count), .error(error)
  );

  always #5 clock = ~clock;

  // Observed strobes and frame ends, sampled away from the active edge.
  logic [26:0] got_q[$];
  int          fd_cnt  = 0;
  int          overlap = 0;
  logic [3:0]  fd_pc   = '0;
  logic        fd_err  = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      if (pixel_valid) got_q.push_back({pixel_index, green, red, blue});
      if (frame_done) begin
        fd_cnt = fd_cnt + 1;
        fd_pc  = pixel_count;
        fd_err = error;
      end
      if (pixel_valid && frame_done) overlap = overlap + 1;
    end
  end

  // Reference model: decodes the pulse widths the bench itself sent.
  logic [26:0] exp_q[$];
  int          m_bits, m_words, base, fd_base;
  logic [23:0] m_sr;
  logic        m_err;
  int          n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic frame_begin();
    exp_q.delete();
    m_bits  = 0;
    m_words = 0;
    m_sr    = '0;
    m_err   = 1'b0;
    base    = got_q.size();
    fd_base = fd_cnt;
  endtask

  task automatic pulse(input int h, input int l);
    neo_data = 1'b1;
    repeat (h) @(negedge clock);
    neo_data = 1'b0;
    repeat (l) @(negedge clock);
    if (h < MIN_HIGH || h > MAX_HIGH) begin
      m_err = 1'b1;
    end else begin
      m_sr = {m_sr[22:0], (h >= BIT_THRESH)};
      m_bits++;
      if (m_bits == 24) begin
        m_bits = 0;
        if (m_words < NUM_PIXELS) exp_q.push_back({m_words[2:0], m_sr});
        else m_err = 1'b1;
        m_words++;
      end
    end
  endtask

  task automatic send_bit(input logic b);
    int h;
    h = b ? int'($urandom_range(MAX_HIGH, BIT_THRESH)) : int'($urandom_range(BIT_THRESH - 1, MIN_HIGH));
    pulse(h, int'($urandom_range(30, 8)));
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  // Bit in send position 5 gets an out-of-range high time.
  task automatic send_word_bad(input logic [23:0] w, input int badh);
    for (int i = 23; i >= 0; i--) begin
      if (23 - i == 5) pulse(badh, 20);
      else send_bit(w[i]);
    end
  endtask

  task automatic latch_check(input string tag);
    int waited;
    logic [26:0] g;
    waited = 0;
    while (fd_cnt == fd_base && waited < LATCH_LOW + 200) begin
      @(negedge clock);
      waited++;
    end
    repeat (5) @(negedge clock);
    check({tag, " frame_done count"}, 64'(fd_cnt - fd_base), 64'd1);
    check({tag, " pixel_count"}, 64'(fd_pc), 64'((m_words > NUM_PIXELS) ? NUM_PIXELS : m_words));
    check({tag, " error"}, 64'(fd_err), 64'(m_err || (m_bits != 0)));
    check({tag, " strobe count"}, 64'(got_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      g = 'x;
      if (base + i < got_q.size()) g = got_q[base + i];
      check({tag, " pixel"}, 64'(g), 64'(exp_q[i]));
    end
  endtask

  logic [23:0] w;
  logic [23:0] last_px;

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset outputs", 64'({pixel_valid, pixel_index, green, red, blue, frame_done, pixel_count, error}), 64'd0);
    reset = 1'b1;
    repeat (LATCH_LOW + 20) @(negedge clock);
    check("no frame_done while syncing", 64'(fd_cnt), 64'd0);

    // T1: nominal timing, single pixel
    frame_begin();
    w = 24'hA53C0F;
    for (int i = 23; i >= 0; i--) pulse(w[i] ? 35 : 18, w[i] ? 28 : 45);
    latch_check("T1");

    // T2: full frame of gray ramps
    frame_begin();
    for (int i = 0; i < NUM_PIXELS; i++) send_word({3{8'(i * 17)}});
    latch_check("T2");

    // T3: one pixel too many
    frame_begin();
    for (int i = 0; i < NUM_PIXELS + 1; i++) send_word(24'($urandom));
    latch_check("T3");

    // T4: glitch, then stuck-high pulse, then a clean frame
    frame_begin();
    send_word_bad(24'($urandom), 4);
    latch_check("T4 short");
    frame_begin();
    send_word_bad(24'($urandom), 60);
    latch_check("T4 long");
    frame_begin();
    send_word(24'($urandom));
    send_word(24'($urandom));
    latch_check("T4 clean");
    last_px = exp_q[exp_q.size() - 1][23:0];

    // T5: partial word only
    frame_begin();
    for (int i = 0; i < 12; i++) send_bit(1'($urandom));
    latch_check("T5");
    check("T5 data hold", 64'({green, red, blue}), 64'(last_px));

    // T6: reset mid-pixel, then traffic with no idle period
    frame_begin();
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    neo_data = 1'b1;
    repeat (10) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("T6 reset outputs", 64'({pixel_valid, pixel_index, green, red, blue, frame_done, pixel_count, error}), 64'd0);
    neo_data = 1'b0;
    reset = 1'b1;
    send_word(24'($urandom));
    repeat (LATCH_LOW + 100) @(negedge clock);
    check("T6 no strobes before idle", 64'(got_q.size() - base), 64'd0);
    check("T6 no frame_done before idle", 64'(fd_cnt - fd_base), 64'd0);
    frame_begin();
    for (int i = 0; i < 3; i++) send_word(24'($urandom));
    latch_check("T6 after");

    // Extra random frames
    for (int f = 0; f < 2; f++) begin
      frame_begin();
      for (int i = 0; i < 1 + f; i++) send_word(24'($urandom));
      latch_check("random frame");
    end

    check("pixel_valid/frame_done overlap", 64'(overlap), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    repeat (150000) @(posedge clock);
    $display("FAIL watchdog: simulation exceeded cycle budget, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
